// File: rtl/f2x_share_sched_if.sv
// Request/result bundle between the requesters, the shared converter scheduler
// and the result consumer.
interface f2x_share_sched_if #(
  parameter int NUM_REQ   = 4,
  parameter int FLOAT_WID = 64,
  parameter int INT_WID   = 32,
  parameter int FRA_WID   = 32,
  parameter int ID_WID    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*FLOAT_WID-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         res_valid;
  logic                         res_ready;
  logic [ID_WID-1:0]            res_id;
  logic [INT_WID-1:0]           res_int;
  logic [FRA_WID-1:0]           res_fra;
  logic [5:0]                   res_flags;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_id, res_int, res_fra, res_flags
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_id, res_int, res_fra, res_flags
  );
endinterface

// File: rtl/f2x_share_sched.sv
// Round-robin scheduler sharing one pipelined float-to-fixed converter among
// NUM_REQ requesters; tracks requester IDs through the pipe and stalls it on backpressure.
module f2x_share_sched #(
  parameter int NUM_REQ   = 4,
  parameter int FLOAT_WID = 64,
  parameter int INT_WID   = 32,
  parameter int FRA_WID   = 32,
  parameter int CONV_LAT  = 5
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              flush,
  f2x_share_sched_if.slave                  bus,
  output logic                              conv_clk_en,
  output logic [FLOAT_WID-1:0]              conv_float_val,
  input  logic [INT_WID-1:0]                conv_int,
  input  logic [FRA_WID-1:0]                conv_fra,
  input  logic [5:0]                        conv_flags,
  output logic [$clog2(CONV_LAT+1)-1:0]     inflight,
  output logic                              idle
);
  localparam int ID_WID  = $clog2(NUM_REQ);
  localparam int CNT_WID = $clog2(CONV_LAT+1);

  logic [CONV_LAT-1:0] slot_vld_r;
  logic [ID_WID-1:0]   slot_id_r [CONV_LAT];
  logic [ID_WID-1:0]   rr_ptr_r;
  logic [CNT_WID-1:0]  inflight_r;

  logic                adv_s;
  logic                grant_any_s;
  logic [ID_WID-1:0]   grant_id_s;
  logic [NUM_REQ-1:0]  grant_s;
  logic [ID_WID:0]     pick_s;
  logic                res_hs_s;
  logic [ID_WID-1:0]   ptr_next_s;

  // Scans downward so the last hit, i.e. the requester nearest at/after ptr, wins.
  function automatic logic [ID_WID:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                               input logic [ID_WID-1:0]  ptr);
    logic [ID_WID:0]   pick;
    logic [ID_WID-1:0] idx;
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ID_WID'((int'(ptr) + i) % NUM_REQ);
      if (vld[idx]) begin
        pick = {1'b1, idx};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Stall, arbitration and operand mux; nothing is granted while frozen, flushing or in reset.
  always_comb begin
    adv_s          = ~(slot_vld_r[CONV_LAT-1] & ~bus.res_ready);
    pick_s         = rr_pick(bus.req_valid & {NUM_REQ{adv_s & ~flush & rstn}}, rr_ptr_r);
    grant_any_s    = pick_s[ID_WID];
    grant_id_s     = pick_s[ID_WID-1:0];
    grant_s        = '0;
    conv_float_val = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_any_s && (grant_id_s == ID_WID'(i))) begin
        grant_s[i]     = 1'b1;
        conv_float_val = bus.req_data[i*FLOAT_WID +: FLOAT_WID];
      end else begin
        grant_s[i]     = 1'b0;
      end
    end
    if (grant_id_s == ID_WID'(NUM_REQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_id_s + ID_WID'(1);
    end
    res_hs_s = slot_vld_r[CONV_LAT-1] & bus.res_ready;
  end

  // Slot tracker mirrors the converter pipe; flush kills all valids even while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_vld_r <= '0;
      for (int i = 0; i < CONV_LAT; i++) slot_id_r[i] <= '0;
    end else if (flush) begin
      slot_vld_r <= '0;
    end else if (adv_s) begin
      slot_vld_r   <= {slot_vld_r[CONV_LAT-2:0], grant_any_s};
      slot_id_r[0] <= grant_id_s;
      for (int i = 1; i < CONV_LAT; i++) slot_id_r[i] <= slot_id_r[i-1];
    end
  end

  // Round-robin pointer advances past the winner only on an actual grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_r <= '0;
    end else if (grant_any_s) begin
      rr_ptr_r <= ptr_next_s;
    end
  end

  // Occupancy counter: accept and result handshake in one cycle cancel out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight_r <= '0;
    end else if (flush) begin
      inflight_r <= '0;
    end else begin
      case ({grant_any_s, res_hs_s})
        2'b10:   inflight_r <= inflight_r + CNT_WID'(1);
        2'b01:   inflight_r <= inflight_r - CNT_WID'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  assign conv_clk_en   = adv_s;
  assign bus.req_ready = grant_s;
  assign bus.res_valid = slot_vld_r[CONV_LAT-1];
  assign bus.res_id    = slot_id_r[CONV_LAT-1];
  assign bus.res_int   = conv_int;
  assign bus.res_fra   = conv_fra;
  assign bus.res_flags = conv_flags;
  assign inflight      = inflight_r;
  assign idle          = (inflight_r == '0) & ~(|bus.req_valid);
endmodule

// File: tb/tb_f2x_share_sched.sv
// Bench for f2x_share_sched: directed vector table, hand-written corner sequences and
// randomized traffic against a queue-based reference model with a behavioural converter.
module tb_f2x_share_sched;
  localparam int NR  = 4;
  localparam int FW  = 64;
  localparam int LAT = 5;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        conv_clk_en;
  logic [63:0] conv_float_val;
  logic [31:0] conv_int;
  logic [31:0] conv_fra;
  logic [5:0]  conv_flags;
  logic [2:0]  inflight;
  logic        idle;

  f2x_share_sched_if #(.NUM_REQ(NR), .FLOAT_WID(FW), .INT_WID(32), .FRA_WID(32)) bus ();

  f2x_share_sched #(.NUM_REQ(NR), .FLOAT_WID(FW), .INT_WID(32), .FRA_WID(32), .CONV_LAT(LAT)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .bus(bus),
    .conv_clk_en(conv_clk_en), .conv_float_val(conv_float_val),
    .conv_int(conv_int), .conv_fra(conv_fra), .conv_flags(conv_flags),
    .inflight(inflight), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Float64 -> Q32.32 with flags {overflow, underflow, nan, infinity, denorm, zero}.
  function automatic logic [69:0] f2x(input logic [63:0] f);
    logic [5:0] fl;
    longint     v;
    real        r;
    fl = 6'b0;
    v  = 0;
    if (f[62:52] == 11'h7FF) begin
      if (f[51:0] != 52'h0) fl = 6'b001000;
      else begin
        fl = 6'b100100;
        v  = f[63] ? 64'sh8000000000000000 : 64'sh7FFFFFFFFFFFFFFF;
      end
    end else if (f[62:52] == 11'h000) begin
      fl = (f[51:0] == 52'h0) ? 6'b000001 : 6'b010010;
    end else begin
      r = $bitstoreal(f) * 4294967296.0;
      if (r >= 9.2e18) begin
        fl = 6'b100000; v = 64'sh7FFFFFFFFFFFFFFF;
      end else if (r <= -9.2e18) begin
        fl = 6'b100000; v = 64'sh8000000000000000;
      end else begin
        v = longint'(r);
        if (v == 0) fl = 6'b010000;
      end
    end
    return {fl, v};
  endfunction

  // Behavioural converter: LAT enabled edges from sample to output.
  logic [63:0] cpipe [LAT];
  logic [69:0] cres;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LAT; i++) cpipe[i] <= 64'h0;
    end else if (conv_clk_en) begin
      cpipe[0] <= conv_float_val;
      for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
    end
  end
  assign cres       = f2x(cpipe[LAT-1]);
  assign conv_int   = cres[63:32];
  assign conv_fra   = cres[31:0];
  assign conv_flags = cres[69:64];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: ops queue in arrival order, each aging one step per enabled edge.
  typedef struct { int id; logic [63:0] f; int age; } ent_t;
  ent_t q[$];
  int   m_ptr  = 0;
  int   last_g = -1;

  task automatic tick(input logic [3:0] rv, input logic [255:0] data,
                      input logic rr, input logic fl, input logic rs);
    logic        exp_vld;
    logic        en;
    int          g;
    logic [3:0]  exp_rdy;
    logic [63:0] exp_fv;
    logic [69:0] er;
    ent_t        e;
    @(negedge clk);
    rstn          = rs;
    bus.req_valid = rv;
    bus.req_data  = data;
    bus.res_ready = rr;
    flush         = fl;
    #1;
    if (!rs) begin
      q.delete();
      m_ptr = 0;
    end
    exp_vld = (q.size() > 0) && (q[0].age == LAT);
    en      = !(exp_vld && !rr);
    g       = -1;
    if (rs && en && !fl) begin
      for (int k = 0; k < NR; k++) begin
        if (g < 0 && rv[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
      end
    end
    exp_rdy = 4'b0;
    exp_fv  = 64'h0;
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      exp_fv     = data[g*64 +: 64];
    end
    chk("m_clk_en", conv_clk_en, en);
    chk("m_req_ready", bus.req_ready, exp_rdy);
    chk("m_float_val", conv_float_val, exp_fv);
    chk("m_res_valid", bus.res_valid, exp_vld);
    chk("m_inflight", inflight, q.size());
    chk("m_idle", idle, (q.size() == 0) && (rv == 4'b0));
    if (exp_vld) begin
      er = f2x(q[0].f);
      chk("m_res_id", bus.res_id, q[0].id);
      chk("m_res_int", bus.res_int, er[63:32]);
      chk("m_res_fra", bus.res_fra, er[31:0]);
      chk("m_res_flags", bus.res_flags, er[69:64]);
    end
    last_g = g;
    if (rs) begin
      if (fl) begin
        q.delete();
      end else if (en) begin
        if (exp_vld && rr) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (g >= 0) begin
          e.id = g; e.f = data[g*64 +: 64]; e.age = 1;
          q.push_back(e);
          m_ptr = (g + 1) % NR;
        end
      end
    end
  endtask

  function automatic logic [63:0] rnd_float();
    logic [63:0] f;
    case ($urandom_range(0, 15))
      0:       f = 64'h0;
      1:       f = 64'hFFF0000000000000;
      2:       f = 64'h7FF8000000000001;
      3:       f = {12'h000, 20'h00001, 32'($urandom)};
      default: begin
        f[63]    = 1'($urandom_range(0, 1));
        f[62:52] = 11'(1003 + $urandom_range(0, 50));
        f[51:32] = 20'($urandom);
        f[31:0]  = 32'($urandom);
      end
    endcase
    return f;
  endfunction

  typedef struct {
    logic [3:0] rv; logic [63:0] data; logic rr; logic chk;
    logic [3:0] ready; logic en; logic vld; logic [1:0] id; logic [2:0] infl;
    logic [31:0] ri; logic [31:0] rf; logic [5:0] flg;
  } vec_t;

  function automatic vec_t mk(logic [3:0] rv, logic [63:0] d, logic rr, logic c,
                              logic [3:0] rdy, logic en, logic vld, logic [1:0] id,
                              logic [2:0] infl, logic [31:0] ri, logic [31:0] rf, logic [5:0] flg);
    vec_t v;
    v.rv = rv; v.data = d; v.rr = rr; v.chk = c; v.ready = rdy; v.en = en; v.vld = vld;
    v.id = id; v.infl = infl; v.ri = ri; v.rf = rf; v.flg = flg;
    return v;
  endfunction

  initial begin
    vec_t        vt[$];
    logic [63:0] one, m25, inf;
    logic [255:0] d2;
    logic [3:0]  pend;
    logic [63:0] pdata [NR];
    logic        rr_r, fl_r;

    one = 64'h3FF0000000000000;
    m25 = 64'hC004000000000000;
    inf = 64'h7FF0000000000000;

    // Requester 2 sends 1.0 from an idle block (pointer at 0).
    vt.push_back(mk(4'b0100, one, 1, 1, 4'b0100, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) vt.push_back(mk(4'b0000, one, 1, 1, 4'b0000, 1, 0, 0, 1, 0, 0, 0));
    vt.push_back(mk(4'b0000, one, 1, 1, 4'b0000, 1, 1, 2, 1, 32'h1, 32'h0, 6'h0));
    vt.push_back(mk(4'b0000, one, 1, 1, 4'b0000, 1, 0, 0, 0, 0, 0, 0));
    // Requester 1 sends -2.5 (pointer at 3); consumer blocks 3 cycles, requester 3 waits.
    vt.push_back(mk(4'b0010, m25, 1, 1, 4'b0010, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) vt.push_back(mk(4'b0000, m25, 1, 1, 4'b0000, 1, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vt.push_back(mk(4'b1000, m25, 0, 1, 4'b0000, 0, 1, 1, 1, 32'hFFFFFFFD, 32'h80000000, 6'h0));
    vt.push_back(mk(4'b1000, m25, 1, 1, 4'b1000, 1, 1, 1, 1, 32'hFFFFFFFD, 32'h80000000, 6'h0));
    vt.push_back(mk(4'b0000, m25, 1, 1, 4'b0000, 1, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 6; i++) vt.push_back(mk(4'b0000, m25, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Requester 3 sends +inf (pointer at 0).
    vt.push_back(mk(4'b1000, inf, 1, 1, 4'b1000, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) vt.push_back(mk(4'b0000, inf, 1, 1, 4'b0000, 1, 0, 0, 1, 0, 0, 0));
    vt.push_back(mk(4'b0000, inf, 1, 1, 4'b0000, 1, 1, 3, 1, 32'h7FFFFFFF, 32'hFFFFFFFF, 6'b100100));
    vt.push_back(mk(4'b0000, inf, 1, 1, 4'b0000, 1, 0, 0, 0, 0, 0, 0));

    rstn = 1'b0; flush = 1'b0; bus.req_valid = '0; bus.req_data = '0; bus.res_ready = 1'b1;

    // Reset state, with requests pending to show no grant leaks out.
    tick(4'b1111, '0, 1, 0, 0);
    chk("rst_req_ready", bus.req_ready, 4'b0000);
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_inflight", inflight, 3'd0);
    chk("rst_clk_en", conv_clk_en, 1'b1);
    tick(4'b0000, '0, 1, 0, 0);
    chk("rst_idle", idle, 1'b1);
    tick(4'b0000, '0, 1, 0, 1);

    foreach (vt[r]) begin
      tick(vt[r].rv, {4{vt[r].data}}, vt[r].rr, 1'b0, 1'b1);
      if (vt[r].chk) begin
        chk("tbl_req_ready", bus.req_ready, vt[r].ready);
        chk("tbl_clk_en", conv_clk_en, vt[r].en);
        chk("tbl_res_valid", bus.res_valid, vt[r].vld);
        chk("tbl_inflight", inflight, vt[r].infl);
        if (vt[r].vld) begin
          chk("tbl_res_id", bus.res_id, vt[r].id);
          chk("tbl_res_int", bus.res_int, vt[r].ri);
          chk("tbl_res_fra", bus.res_fra, vt[r].rf);
          chk("tbl_res_flags", bus.res_flags, vt[r].flg);
        end
      end
    end

    // All four requesters continuously valid: 0,1,2,3,... and back-to-back results.
    d2 = {rnd_float(), rnd_float(), rnd_float(), rnd_float()};
    for (int c = 0; c < 12; c++) begin
      tick(4'b1111, d2, 1, 0, 1);
      chk("rr_grant", bus.req_ready, 4'b0001 << (c % 4));
      chk("rr_inflight", inflight, (c < 5) ? c : 5);
      if (c >= 5) begin
        chk("rr_res_valid", bus.res_valid, 1'b1);
        chk("rr_res_id", bus.res_id, (c - 5) % 4);
      end
    end
    for (int c = 0; c < 6; c++) tick(4'b0000, d2, 1, 0, 1);

    // Flush with three operations in flight.
    for (int c = 0; c < 3; c++) tick(4'b1111, d2, 1, 0, 1);
    tick(4'b1111, d2, 1, 1, 1);
    chk("fl_no_grant", bus.req_ready, 4'b0000);
    chk("fl_inflight_pre", inflight, 3'd3);
    tick(4'b0000, d2, 1, 0, 1);
    chk("fl_res_valid", bus.res_valid, 1'b0);
    chk("fl_inflight", inflight, 3'd0);
    for (int c = 0; c < 10; c++) begin
      tick(4'b0000, d2, 1, 0, 1);
      chk("fl_no_late", bus.res_valid, 1'b0);
    end

    // One-cycle reset mid-stream.
    for (int c = 0; c < 7; c++) tick(4'b1111, d2, 1, 0, 1);
    tick(4'b1111, d2, 1, 0, 0);
    chk("mr_res_valid", bus.res_valid, 1'b0);
    chk("mr_req_ready", bus.req_ready, 4'b0000);
    chk("mr_inflight", inflight, 3'd0);
    tick(4'b1111, d2, 1, 0, 1);
    chk("mr_grant0", bus.req_ready, 4'b0001);
    for (int c = 0; c < 4; c++) begin
      tick(4'b0000, d2, 1, 0, 1);
      chk("mr_no_stale", bus.res_valid, 1'b0);
    end
    tick(4'b0000, d2, 1, 0, 1);
    chk("mr_first_res", bus.res_valid, 1'b1);
    chk("mr_first_id", bus.res_id, 2'd0);

    // Random traffic; requesters hold valid/data until accepted.
    pend = 4'b0;
    for (int i = 0; i < NR; i++) pdata[i] = 64'h0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i]  = 1'b1;
          pdata[i] = rnd_float();
        end
      end
      rr_r = ($urandom_range(0, 3) != 0);
      fl_r = ($urandom_range(0, 39) == 0);
      tick(pend, {pdata[3], pdata[2], pdata[1], pdata[0]}, rr_r, fl_r, 1);
      if (last_g >= 0) pend[last_g] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
